dcache_store_drain: RTL and testbench
=====================================

Name: dcache_store_drain

Overview:
- Drains committed stores from the data-cache store buffer into the data-cache arrays, one store at a time, oldest first.
- Pops the buffer's oldest entry and looks up its tag.
- On a hit, byte-merges the store into the resident line.
- On a miss, fetches the line from memory, merges the store, and installs the line into the way carried by the entry.
- Sits between the store buffer (upstream) and the dcache tag/data arrays plus the memory request port (downstream).

Parameters:
- ADDR_W, 32, byte address width.
- LINE_BYTES, 16, cache line size in bytes (power of 2).
- WAYS, 4, associativity.
- SET_W, 2, set index width.
- CNT_W, 16, width of the drained-store counter.

Ports:
- clock in 1: core clock.
- reset in 1: synchronous, active-high reset.
- sb_empty in 1: 1 = store buffer holds no valid entry.
- sb_full in 1: 1 = every store buffer entry is valid.
- sb_get_oldest out 1: single-cycle pop of the oldest entry.
- sb_oldest in store_buffer_t: oldest entry (addr, way, thread_id, data, size); valid in the same cycle as a pop.
- ld_pending in 1: load pipeline wants the cache this cycle.
- tag_rd_valid out 1: tag lookup request.
- tag_rd_set out SET_W: set to look up.
- tag_rd_hit in WAYS: one-hot hit vector, returned 1 cycle after tag_rd_valid.
- data_wr_valid out 1: data/tag write request.
- data_wr_ready in 1: array accepts the write.
- data_wr_set out SET_W: set to write.
- data_wr_way out log2(WAYS): way to write.
- data_wr_tag out ADDR_W-SET_W-log2(LINE_BYTES): tag to write.
- data_wr_fill out 1: 1 = full install (tag + valid + line); 0 = byte update.
- data_wr_be out LINE_BYTES: byte enables.
- data_wr_line out 8*LINE_BYTES: line data.
- mem_req_valid out 1: line fill request.
- mem_req_ready in 1: memory accepts the request.
- mem_req_addr out ADDR_W: line-aligned fill address.
- mem_rsp_valid in 1: fill data valid.
- mem_rsp_data in 8*LINE_BYTES: fill line.
- busy out 1: 1 whenever the FSM is not in IDLE.
- err_misaligned out 1: sticky misaligned-store flag.
- drain_count out CNT_W: stores completed.

Behaviour:
- Reset (synchronous, active-high) forces:
  - FSM to IDLE.
  - All request outputs to 0.
  - err_misaligned to 0 and drain_count to 0.
  - Any latched store is discarded.
- Reset during MISS_WAIT: a late mem_rsp_valid is ignored, because IDLE never samples mem_rsp.
- FSM states: IDLE, LOOKUP, RESOLVE, WRITE, MISS_REQ, MISS_WAIT, FILL.
- IDLE:
  - Condition: if !sb_empty && (!ld_pending || sb_full), assert sb_get_oldest for exactly 1 cycle and latch sb_oldest.
  - Full buffer: sb_full overrides ld_pending, so a full buffer always drains.
  - Misaligned store (size half with addr[0]=1, or size word with addr[1:0]!=0):
    - set err_misaligned;
    - drop the store, with no cache or memory access and no drain_count increment;
    - stay in IDLE.
  - Otherwise go to LOOKUP.
- LOOKUP: assert tag_rd_valid for 1 cycle with the latched set, then go to RESOLVE.
- RESOLVE: sample tag_rd_hit.
  - Nonzero: go to WRITE. The hit way is the encoded index of tag_rd_hit; the entry's way field is ignored.
  - Zero: go to MISS_REQ.
  - A hit vector with more than one bit set is an assertion failure.
- WRITE:
  - Drive data_wr_fill=0.
  - Byte enables: data_wr_be = size mask (byte 1, half 3, word 0xF) shifted left by the line offset.
  - Data: data_wr_line = store data replicated so it lands at the offset.
  - Hold data_wr_valid and all payload stable until data_wr_ready.
  - Handshake cycle: increment drain_count and go to IDLE.
- MISS_REQ: hold mem_req_valid with the line-aligned address until mem_req_ready, then go to MISS_WAIT.
- MISS_WAIT: wait for mem_rsp_valid; latch mem_rsp_data with the store bytes overwritten at the offset, then go to FILL.
- FILL:
  - Drive data_wr_fill=1, data_wr_be all ones, data_wr_way = entry way, data_wr_tag = entry tag.
  - Hold until data_wr_ready, then increment drain_count and go to IDLE.
- One store in flight; no second pop occurs before the return to IDLE.
- The fastest hit is 4 cycles from pop to IDLE (pop, lookup, resolve, write with ready=1); a new pop can issue in the next cycle.
- drain_count saturates at all ones.
- Address split: offset = addr[log2(LINE_BYTES)-1:0]; set = next SET_W bits; tag = remaining upper bits.

Decomposition:
- Shared package (dcache defines):
  - store_buffer_t;
  - store size encoding (0 byte, 1 half, 2 word);
  - tag/set/offset range macros;
  - LINE_BYTES and WAYS constants.
- One sub-module, store_line_merge: combinational; from offset, size, store data and base line, produces the byte-enable mask and merged line. It is reused for the hit write and the fill merge.

Test Plan:
- Hit byte store:
  - Stimulus: addr 0x0000_1043, data 0xAB, size byte, tag_rd_hit=4'b0100, data_wr_ready=1.
  - Response: pop in cycle 0 and tag_rd_valid in cycle 1; in cycle 3, data_wr_valid with set 0, way 2, be 0x0008, line byte 3 = 0xAB; drain_count=1.
- Miss word store:
  - Stimulus: addr 0x0000_2078, data 0xDEADBEEF, entry way 1, hit=0; fill data has bytes 0x00..0x0F.
  - Response: mem_req_addr 0x0000_2070; FILL with way 1, be 0xFFFF; line bytes 8..11 = EF BE AD DE, other bytes unchanged.
- Drain gating:
  - ld_pending=1, sb_full=0, sb_empty=0 for 10 cycles -> no pop.
  - Then raise sb_full -> pop the next cycle.
  - sb_empty=1 -> never pop.
- Backpressure: data_wr_ready low for 3 cycles in WRITE -> payload stable, sb_get_oldest stays 0, drain_count increments once.
- Misaligned: half store at offset 1 -> err_misaligned=1 and stays 1, no tag_rd_valid, drain_count unchanged; the following aligned store drains normally.
- Reset in MISS_WAIT: assert reset 1 cycle -> busy=0 and all outputs 0 next cycle; a mem_rsp_valid 2 cycles later causes no write.

Source files
------------

// File: rtl/dcache_store_drain_pkg.sv
// Shared dcache definitions: store buffer entry, size encoding, address field
// positions and the drain FSM state type.
package dcache_store_drain_pkg;

  localparam int DC_ADDR_W     = 32;
  localparam int DC_LINE_BYTES = 16;
  localparam int DC_WAYS       = 4;
  localparam int DC_SET_W      = 2;
  localparam int DC_DATA_W     = 32;
  localparam int DC_TID_W      = 2;

  // Address split: [TAG | SET | OFFSET]
  localparam int DC_OFF_W   = $clog2(DC_LINE_BYTES);
  localparam int DC_WAY_W   = $clog2(DC_WAYS);
  localparam int DC_SET_LSB = DC_OFF_W;
  localparam int DC_TAG_LSB = DC_OFF_W + DC_SET_W;
  localparam int DC_TAG_W   = DC_ADDR_W - DC_TAG_LSB;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } st_size_e;

  typedef struct packed {
    logic [DC_ADDR_W-1:0] addr;
    logic [DC_WAY_W-1:0]  way;
    logic [DC_TID_W-1:0]  thread_id;
    logic [DC_DATA_W-1:0] data;
    st_size_e             size;
  } store_buffer_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_RESOLVE, ST_WRITE, ST_MISS_REQ, ST_MISS_WAIT, ST_FILL
  } drain_state_e;

  function automatic logic is_misaligned(input logic [1:0] lo, input st_size_e size);
    return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dcache_store_drain_merge.sv
// Combinational byte merge: places a store at its line offset and overlays it
// on a base line; shared by the hit write and the miss fill.
module store_line_merge
  import dcache_store_drain_pkg::*;
#(
  parameter int LINE_BYTES = DC_LINE_BYTES
) (
  input  logic [$clog2(LINE_BYTES)-1:0] off_i,
  input  st_size_e                      size_i,
  input  logic [DC_DATA_W-1:0]          data_i,
  input  logic [8*LINE_BYTES-1:0]       base_i,
  output logic [LINE_BYTES-1:0]         be_o,
  output logic [8*LINE_BYTES-1:0]       line_o
);

  logic [LINE_BYTES-1:0]   mask;
  logic [8*LINE_BYTES-1:0] data_sh;

  always_comb begin
    unique case (size_i)
      SZ_BYTE: mask = LINE_BYTES'(4'h1);
      SZ_HALF: mask = LINE_BYTES'(4'h3);
      default: mask = LINE_BYTES'(4'hF);
    endcase
    be_o    = mask << off_i;
    data_sh = (8*LINE_BYTES)'(data_i) << {off_i, 3'b000};
    line_o  = base_i;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (be_o[b]) line_o[8*b +: 8] = data_sh[8*b +: 8];
    end
  end

endmodule

// File: rtl/dcache_store_drain.sv
// Store-buffer drain: pops the oldest committed store, looks up its tag, then
// either byte-writes the hit line or fetches, merges and installs the miss line.
module dcache_store_drain
  import dcache_store_drain_pkg::*;
#(
  parameter int ADDR_W     = DC_ADDR_W,
  parameter int LINE_BYTES = DC_LINE_BYTES,
  parameter int WAYS       = DC_WAYS,
  parameter int SET_W      = DC_SET_W,
  parameter int CNT_W      = 16
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          sb_empty,
  input  logic                                          sb_full,
  output logic                                          sb_get_oldest,
  input  store_buffer_t                                 sb_oldest,
  input  logic                                          ld_pending,
  output logic                                          tag_rd_valid,
  output logic [SET_W-1:0]                              tag_rd_set,
  input  logic [WAYS-1:0]                               tag_rd_hit,
  output logic                                          data_wr_valid,
  input  logic                                          data_wr_ready,
  output logic [SET_W-1:0]                              data_wr_set,
  output logic [$clog2(WAYS)-1:0]                       data_wr_way,
  output logic [ADDR_W-SET_W-$clog2(LINE_BYTES)-1:0]    data_wr_tag,
  output logic                                          data_wr_fill,
  output logic [LINE_BYTES-1:0]                         data_wr_be,
  output logic [8*LINE_BYTES-1:0]                       data_wr_line,
  output logic                                          mem_req_valid,
  input  logic                                          mem_req_ready,
  output logic [ADDR_W-1:0]                             mem_req_addr,
  input  logic                                          mem_rsp_valid,
  input  logic [8*LINE_BYTES-1:0]                       mem_rsp_data,
  output logic                                          busy,
  output logic                                          err_misaligned,
  output logic [CNT_W-1:0]                              drain_count
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LINE_W = 8*LINE_BYTES;

  drain_state_e        state_q, state_d;
  store_buffer_t       st_q, st_d;
  logic [WAY_W-1:0]    hit_way_q, hit_way_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [WAY_W-1:0]      hit_idx;
  logic [LINE_W-1:0]     mrg_base, mrg_line;
  logic [LINE_BYTES-1:0] mrg_be;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  unused_tid;

  assign unused_tid = ^st_q.thread_id;

  // Base is the fill line only while waiting on memory; a hit write carries just the store bytes.
  assign mrg_base = (state_q == ST_MISS_WAIT) ? mem_rsp_data : '0;

  store_line_merge #(.LINE_BYTES(LINE_BYTES)) u_merge (
    .off_i  (st_q.addr[OFF_W-1:0]),
    .size_i (st_q.size),
    .data_i (st_q.data),
    .base_i (mrg_base),
    .be_o   (mrg_be),
    .line_o (mrg_line)
  );

  always_comb begin
    hit_idx = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (tag_rd_hit[w]) hit_idx = hit_idx | WAY_W'(w);
    end
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    st_d          = st_q;
    hit_way_d     = hit_way_q;
    line_d        = line_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    sb_get_oldest = 1'b0;
    tag_rd_valid  = 1'b0;
    data_wr_valid = 1'b0;
    data_wr_fill  = 1'b0;
    data_wr_be    = '0;
    data_wr_line  = '0;
    mem_req_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A full buffer drains even while loads want the cache.
        if (!reset && !sb_empty && (!ld_pending || sb_full)) begin
          sb_get_oldest = 1'b1;
          st_d          = sb_oldest;
          if (is_misaligned(sb_oldest.addr[1:0], sb_oldest.size)) err_d   = 1'b1;
          else                                                     state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        tag_rd_valid = 1'b1;
        state_d      = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        hit_way_d = hit_idx;
        state_d   = (|tag_rd_hit) ? ST_WRITE : ST_MISS_REQ;
      end
      ST_WRITE: begin
        data_wr_valid = 1'b1;
        data_wr_be    = mrg_be;
        data_wr_line  = mrg_line;
        if (data_wr_ready) begin
          cnt_d   = cnt_inc;
          state_d = ST_IDLE;
        end
      end
      ST_MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        if (mem_rsp_valid) begin
          line_d  = mrg_line;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        data_wr_valid = 1'b1;
        data_wr_fill  = 1'b1;
        data_wr_be    = '1;
        data_wr_line  = line_q;
        if (data_wr_ready) begin
          cnt_d   = cnt_inc;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      st_q      <= '0;
      hit_way_q <= '0;
      line_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      st_q      <= st_d;
      hit_way_q <= hit_way_d;
      line_q    <= line_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign tag_rd_set     = st_q.addr[OFF_W +: SET_W];
  assign data_wr_set    = st_q.addr[OFF_W +: SET_W];
  assign data_wr_way    = (state_q == ST_FILL) ? st_q.way : hit_way_q;
  assign data_wr_tag    = st_q.addr[ADDR_W-1:OFF_W+SET_W];
  assign mem_req_addr   = {st_q.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign busy           = (state_q != ST_IDLE);
  assign err_misaligned = err_q;
  assign drain_count    = cnt_q;

  hit_onehot_a: assert property (@(posedge clock) disable iff (reset)
    (state_q == ST_RESOLVE) |-> $onehot0(tag_rd_hit));

endmodule

// File: tb/tb_dcache_store_drain.sv
// Self-checking bench for dcache_store_drain: acts as store buffer, tag array
// and memory, and checks each drained store against a byte-level model.
module tb_dcache_store_drain;
  import dcache_store_drain_pkg::*;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          sb_empty, sb_full, sb_get_oldest, ld_pending;
  store_buffer_t sb_oldest;
  logic          tag_rd_valid;
  logic [1:0]    tag_rd_set;
  logic [3:0]    tag_rd_hit;
  logic          data_wr_valid, data_wr_ready, data_wr_fill;
  logic [1:0]    data_wr_set, data_wr_way;
  logic [25:0]   data_wr_tag;
  logic [15:0]   data_wr_be;
  logic [127:0]  data_wr_line;
  logic          mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0]   mem_req_addr;
  logic [127:0]  mem_rsp_data;
  logic          busy, err_misaligned;
  logic [CNT_W-1:0] drain_count;

  int tests = 0;
  int fails = 0;
  int model_cnt = 0;

  typedef struct {
    int pop_cyc, tag_cyc, wr_cyc, tag_cnt, wr_cnt, req_cnt, extra_pop;
    bit unstable, timeout;
    logic [1:0] tag_set, wr_set, wr_way;
    logic [25:0] wr_tag;
    logic wr_fill;
    logic [15:0] wr_be;
    logic [127:0] wr_line;
    logic [31:0] req_addr;
  } obs_t;

  always #5 clock = ~clock;

  dcache_store_drain #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .sb_empty(sb_empty), .sb_full(sb_full),
    .sb_get_oldest(sb_get_oldest), .sb_oldest(sb_oldest), .ld_pending(ld_pending),
    .tag_rd_valid(tag_rd_valid), .tag_rd_set(tag_rd_set), .tag_rd_hit(tag_rd_hit),
    .data_wr_valid(data_wr_valid), .data_wr_ready(data_wr_ready), .data_wr_set(data_wr_set),
    .data_wr_way(data_wr_way), .data_wr_tag(data_wr_tag), .data_wr_fill(data_wr_fill),
    .data_wr_be(data_wr_be), .data_wr_line(data_wr_line), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .busy(busy), .err_misaligned(err_misaligned),
    .drain_count(drain_count)
  );

  // Reference: the store's bytes, little-endian, land at addr % 16; a fill keeps the other bytes.
  function automatic void model_store(input logic [31:0] addr, input logic [31:0] data,
                                      input int nbytes, input logic [127:0] base,
                                      output logic [15:0] be, output logic [127:0] line);
    int off;
    off  = int'(addr % 16);
    be   = '0;
    line = base;
    for (int k = 0; k < nbytes; k++) begin
      be[off+k] = 1'b1;
      line[8*(off+k) +: 8] = data[8*k +: 8];
    end
  endfunction

  function automatic logic [127:0] byte_mask(input logic [15:0] be);
    logic [127:0] m;
    for (int b = 0; b < 16; b++) m[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] h);
    for (int w = 0; w < 4; w++) if (h[w]) return 2'(w);
    return 2'd0;
  endfunction

  function automatic void sat_inc();
    if (model_cnt < CNT_MAX) model_cnt++;
  endfunction

  task automatic idle_inputs();
    sb_empty = 1'b1; sb_full = 1'b0; ld_pending = 1'b0; sb_oldest = '0;
    tag_rd_hit = '0; data_wr_ready = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_cnt = 0;
  endtask

  // Plays store buffer / tag array / memory for one store and records what the DUT did.
  task automatic run_store(input store_buffer_t st, input logic [3:0] hit, input logic [127:0] fill,
                           input int wr_stall, input int rsp_dly, output obs_t o);
    bit popped = 0, tag_prev = 0, done = 0;
    int rsp_cnt = -1, wr_wait = 0;
    o = '{pop_cyc: -1, tag_cyc: -1, wr_cyc: -1, default: 0};
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      if (popped && !busy) begin done = 1; break; end
      sb_empty      = 1'b0;   // more entries remain queued behind the popped one
      sb_oldest     = st;
      ld_pending    = 1'b0;
      sb_full       = 1'b0;
      tag_rd_hit    = tag_prev ? hit : 4'($urandom);
      data_wr_ready = data_wr_valid && (wr_wait >= wr_stall);
      mem_req_ready = mem_req_valid && ($urandom_range(1) == 1);
      mem_rsp_valid = (rsp_cnt == 0);
      mem_rsp_data  = mem_rsp_valid ? fill : {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (sb_get_oldest) begin
        if (popped) o.extra_pop++;
        else begin popped = 1; o.pop_cyc = c; end
      end
      tag_prev = tag_rd_valid;
      if (tag_rd_valid) begin o.tag_cnt++; o.tag_cyc = c - o.pop_cyc; o.tag_set = tag_rd_set; end
      if (data_wr_valid) begin
        if (wr_wait == 0) begin
          o.wr_set = data_wr_set; o.wr_way = data_wr_way; o.wr_tag = data_wr_tag;
          o.wr_fill = data_wr_fill; o.wr_be = data_wr_be; o.wr_line = data_wr_line;
        end else if (o.wr_set !== data_wr_set || o.wr_way !== data_wr_way || o.wr_tag !== data_wr_tag ||
                     o.wr_fill !== data_wr_fill || o.wr_be !== data_wr_be || o.wr_line !== data_wr_line)
          o.unstable = 1;
        if (data_wr_ready) begin o.wr_cnt++; o.wr_cyc = c - o.pop_cyc; wr_wait = 0; end
        else wr_wait++;
      end
      if (rsp_cnt == 0) rsp_cnt = -1;
      else if (rsp_cnt > 0) rsp_cnt--;
      if (mem_req_valid && mem_req_ready) begin o.req_cnt++; o.req_addr = mem_req_addr; rsp_cnt = rsp_dly; end
    end
    sb_empty = 1'b1;
    o.timeout = !done;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    tests++; if ({busy, sb_get_oldest, tag_rd_valid, data_wr_valid, mem_req_valid} !== 5'b0) begin
      fails++; $display("FAIL reset_outputs got %b want 00000",
                        {busy, sb_get_oldest, tag_rd_valid, data_wr_valid, mem_req_valid}); end
    tests++; if (err_misaligned !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err_misaligned); end
    tests++; if (drain_count !== '0) begin fails++; $display("FAIL reset_count got %0d want 0", drain_count); end
  endtask

  task automatic test_hit_byte();
    store_buffer_t st; obs_t o;
    st = '0; st.addr = 32'h0000_1043; st.data = 32'h0000_00AB; st.size = SZ_BYTE; st.way = 2'd0;
    run_store(st, 4'b0100, '0, 0, 0, o);
    sat_inc();
    tests++; if (o.timeout) begin fails++; $display("FAIL hit_byte_timeout got timeout want completion"); end
    tests++; if (o.tag_cyc !== 1) begin fails++; $display("FAIL hit_byte_tag_cycle got %0d want 1", o.tag_cyc); end
    tests++; if (o.wr_cyc !== 3) begin fails++; $display("FAIL hit_byte_wr_cycle got %0d want 3", o.wr_cyc); end
    tests++; if ({o.wr_set, o.wr_way, o.wr_fill} !== {2'd0, 2'd2, 1'b0}) begin fails++;
      $display("FAIL hit_byte_set_way_fill got %0d/%0d/%b want 0/2/0", o.wr_set, o.wr_way, o.wr_fill); end
    tests++; if (o.wr_be !== 16'h0008) begin fails++; $display("FAIL hit_byte_be got %h want 0008", o.wr_be); end
    tests++; if (o.wr_line[31:24] !== 8'hAB) begin fails++; $display("FAIL hit_byte_data got %h want ab", o.wr_line[31:24]); end
    tests++; if (drain_count !== CNT_W'(model_cnt)) begin fails++;
      $display("FAIL hit_byte_count got %0d want %0d", drain_count, model_cnt); end
  endtask

  task automatic test_miss_word();
    store_buffer_t st; obs_t o; logic [127:0] fill, exp_line;
    for (int b = 0; b < 16; b++) fill[8*b +: 8] = 8'(b);
    exp_line = fill; exp_line[95:64] = 32'hDEADBEEF;
    st = '0; st.addr = 32'h0000_2078; st.data = 32'hDEADBEEF; st.size = SZ_WORD; st.way = 2'd1;
    run_store(st, 4'b0000, fill, 1, 2, o);
    sat_inc();
    tests++; if (o.timeout) begin fails++; $display("FAIL miss_word_timeout got timeout want completion"); end
    tests++; if (o.req_addr !== 32'h0000_2070) begin fails++; $display("FAIL miss_word_req_addr got %h want 00002070", o.req_addr); end
    tests++; if ({o.wr_fill, o.wr_way, o.wr_set} !== {1'b1, 2'd1, 2'd3}) begin fails++;
      $display("FAIL miss_word_fill_way_set got %b/%0d/%0d want 1/1/3", o.wr_fill, o.wr_way, o.wr_set); end
    tests++; if (o.wr_be !== 16'hFFFF) begin fails++; $display("FAIL miss_word_be got %h want ffff", o.wr_be); end
    tests++; if (o.wr_tag !== 26'h81) begin fails++; $display("FAIL miss_word_tag got %h want 81", o.wr_tag); end
    tests++; if (o.wr_line !== exp_line) begin fails++; $display("FAIL miss_word_line got %h want %h", o.wr_line, exp_line); end
    tests++; if (drain_count !== CNT_W'(model_cnt)) begin fails++;
      $display("FAIL miss_word_count got %0d want %0d", drain_count, model_cnt); end
  endtask

  task automatic test_gating();
    int pops = 0; bit done = 0; bit popped_full;
    store_buffer_t st;
    st = '0; st.addr = 32'h0000_4010; st.data = 32'h11; st.size = SZ_BYTE;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock); sb_oldest = st; sb_empty = 1'b0; ld_pending = 1'b1; sb_full = 1'b0;
      #1; if (sb_get_oldest) pops++;
    end
    tests++; if (pops !== 0) begin fails++; $display("FAIL gate_ld_pending got %0d pops want 0", pops); end
    @(negedge clock); sb_full = 1'b1;
    #1; popped_full = sb_get_oldest;
    tests++; if (popped_full !== 1'b1) begin fails++; $display("FAIL gate_full_override got %b want 1", popped_full); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); sb_empty = 1'b1; sb_full = 1'b0; ld_pending = 1'b0;
      tag_rd_hit = 4'b0001; data_wr_ready = 1'b1;
      #1; if (!busy) begin done = 1; break; end
    end
    data_wr_ready = 1'b0;
    if (popped_full) sat_inc();
    tests++; if (!done) begin fails++; $display("FAIL gate_drain_timeout got busy want idle"); end
    tests++; if (drain_count !== CNT_W'(model_cnt)) begin fails++;
      $display("FAIL gate_count got %0d want %0d", drain_count, model_cnt); end
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock); sb_empty = 1'b1; sb_full = (c % 2 == 0); ld_pending = 1'b0;
      #1; if (sb_get_oldest) pops++;
    end
    sb_full = 1'b0;
    tests++; if (pops !== 0) begin fails++; $display("FAIL gate_empty got %0d pops want 0", pops); end
  endtask

  task automatic test_backpressure();
    store_buffer_t st; obs_t o; logic [15:0] be; logic [127:0] line;
    st = '0; st.addr = 32'h0000_5026; st.data = 32'h0000_C0DE; st.size = SZ_HALF;
    run_store(st, 4'b1000, '0, 3, 0, o);
    sat_inc();
    model_store(st.addr, st.data, 2, '0, be, line);
    tests++; if (o.unstable) begin fails++; $display("FAIL bp_stable got changing payload want stable"); end
    tests++; if (o.extra_pop !== 0) begin fails++; $display("FAIL bp_no_pop got %0d pops want 0", o.extra_pop); end
    tests++; if (o.wr_cnt !== 1 || o.wr_cyc !== 6) begin fails++;
      $display("FAIL bp_handshake got %0d at cycle %0d want 1 at cycle 6", o.wr_cnt, o.wr_cyc); end
    tests++; if (o.wr_be !== be || (o.wr_line & byte_mask(be)) !== line) begin fails++;
      $display("FAIL bp_payload got %h/%h want %h/%h", o.wr_be, o.wr_line, be, line); end
    tests++; if (drain_count !== CNT_W'(model_cnt)) begin fails++;
      $display("FAIL bp_count got %0d want %0d", drain_count, model_cnt); end
  endtask

  task automatic test_misaligned();
    store_buffer_t st; obs_t o;
    st = '0; st.addr = 32'h0000_1001; st.data = 32'h1234; st.size = SZ_HALF;
    run_store(st, 4'b0001, '0, 0, 0, o);
    tests++; if (err_misaligned !== 1'b1) begin fails++; $display("FAIL misalign_err got %b want 1", err_misaligned); end
    tests++; if (o.tag_cnt + o.wr_cnt + o.req_cnt !== 0 || o.timeout) begin fails++;
      $display("FAIL misalign_no_access got tag %0d wr %0d req %0d want 0 0 0", o.tag_cnt, o.wr_cnt, o.req_cnt); end
    tests++; if (drain_count !== CNT_W'(model_cnt)) begin fails++;
      $display("FAIL misalign_count got %0d want %0d", drain_count, model_cnt); end
    st.addr = 32'h0000_1005; st.size = SZ_BYTE;
    run_store(st, 4'b0010, '0, 0, 0, o);
    sat_inc();
    tests++; if (o.wr_cnt !== 1 || o.wr_be !== 16'h0020) begin fails++;
      $display("FAIL misalign_next got %0d writes be %h want 1 writes be 0020", o.wr_cnt, o.wr_be); end
    tests++; if (err_misaligned !== 1'b1 || drain_count !== CNT_W'(model_cnt)) begin fails++;
      $display("FAIL misalign_sticky got err %b cnt %0d want 1 %0d", err_misaligned, drain_count, model_cnt); end
  endtask

  task automatic test_random();
    store_buffer_t st; obs_t o; logic [3:0] hit; logic [127:0] fill, line; logic [15:0] be;
    int sz; bit is_hit;
    for (int i = 0; i < 30; i++) begin
      sz = $urandom_range(2);
      st = '0;
      st.addr = $urandom & ~((32'(1) << sz) - 1);
      st.data = $urandom; st.size = st_size_e'(2'(sz)); st.way = 2'($urandom); st.thread_id = 2'($urandom);
      is_hit = ($urandom_range(1) == 1);
      hit = is_hit ? (4'b0001 << $urandom_range(3)) : 4'b0000;
      fill = {$urandom, $urandom, $urandom, $urandom};
      run_store(st, hit, fill, $urandom_range(2), $urandom_range(3), o);
      sat_inc();
      model_store(st.addr, st.data, 1 << sz, is_hit ? 128'b0 : fill, be, line);
      if (!is_hit) be = 16'hFFFF;
      tests++; if (o.timeout || o.tag_cnt !== 1 || o.wr_cnt !== 1 || o.extra_pop !== 0 || o.unstable) begin fails++;
        $display("FAIL rnd_flow[%0d] got to %b tag %0d wr %0d pop %0d unst %b", i, o.timeout, o.tag_cnt, o.wr_cnt, o.extra_pop, o.unstable); end
      tests++; if (o.tag_set !== st.addr[5:4] || o.wr_set !== st.addr[5:4] || o.wr_tag !== st.addr[31:6]) begin fails++;
        $display("FAIL rnd_set_tag[%0d] got %0d/%0d/%h want %0d/%h", i, o.tag_set, o.wr_set, o.wr_tag, st.addr[5:4], st.addr[31:6]); end
      tests++; if (o.wr_way !== (is_hit ? onehot_idx(hit) : st.way) || o.wr_fill !== !is_hit) begin fails++;
        $display("FAIL rnd_way_fill[%0d] got %0d/%b want %0d/%b", i, o.wr_way, o.wr_fill, is_hit ? onehot_idx(hit) : st.way, !is_hit); end
      tests++; if (o.wr_be !== be || (o.wr_line & byte_mask(be)) !== (line & byte_mask(be))) begin fails++;
        $display("FAIL rnd_payload[%0d] got %h/%h want %h/%h", i, o.wr_be, o.wr_line, be, line); end
      tests++; if (o.req_cnt !== (is_hit ? 0 : 1) || (!is_hit && o.req_addr !== {st.addr[31:4], 4'h0})) begin fails++;
        $display("FAIL rnd_mem_req[%0d] got %0d at %h want %0d", i, o.req_cnt, o.req_addr, is_hit ? 0 : 1); end
      tests++; if (drain_count !== CNT_W'(model_cnt)) begin fails++;
        $display("FAIL rnd_count[%0d] got %0d want %0d", i, drain_count, model_cnt); end
    end
    tests++; if (err_misaligned !== 1'b1) begin fails++; $display("FAIL rnd_err_sticky got %b want 1", err_misaligned); end
  endtask

  task automatic test_reset_miss_wait();
    store_buffer_t st; bit got_req = 0; bit in_wait; int stray = 0;
    st = '0; st.addr = 32'h0000_3070; st.data = 32'h5555AAAA; st.size = SZ_WORD; st.way = 2'd3;
    @(negedge clock); sb_oldest = st; sb_empty = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); sb_empty = 1'b1; tag_rd_hit = 4'b0000; mem_req_ready = 1'b1;
      #1; if (mem_req_valid) begin got_req = 1; break; end
    end
    tests++; if (!got_req) begin fails++; $display("FAIL rst_wait_req got no request want request"); end
    @(negedge clock); mem_req_ready = 1'b0;
    #1; in_wait = busy && !mem_req_valid && !data_wr_valid;
    tests++; if (!in_wait) begin fails++; $display("FAIL rst_wait_state got busy %b want waiting", busy); end
    reset = 1'b1;
    @(negedge clock); reset = 1'b0; model_cnt = 0;
    #1;
    tests++; if ({busy, sb_get_oldest, tag_rd_valid, data_wr_valid, mem_req_valid, err_misaligned} !== 6'b0
                 || drain_count !== '0) begin fails++;
      $display("FAIL rst_wait_outputs got %b cnt %0d want 000000 cnt 0",
               {busy, sb_get_oldest, tag_rd_valid, data_wr_valid, mem_req_valid, err_misaligned}, drain_count); end
    @(negedge clock);
    @(negedge clock); mem_rsp_valid = 1'b1; mem_rsp_data = {4{32'hFACEFEED}};
    for (int c = 0; c < 6; c++) begin
      #1; if (data_wr_valid || busy) stray++;
      @(negedge clock); mem_rsp_valid = 1'b0;
    end
    tests++; if (stray !== 0 || drain_count !== '0) begin fails++;
      $display("FAIL rst_wait_late_rsp got %0d busy cycles cnt %0d want 0 0", stray, drain_count); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_hit_byte();
    test_miss_word();
    test_gating();
    test_backpressure();
    test_misaligned();
    test_random();
    test_reset_miss_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
